// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions: opcode/func encodings, reset PC, instruction field
// positions and the branch-offset helper used by the fetch stage.
package mips_defs_pkg;

  // Default reset PC, which is also the ROM base address
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_JAL   = 6'h03;

  // R-type function codes
  localparam logic [5:0] FUNC_ADDU = 6'h21;
  localparam logic [5:0] FUNC_SUBU = 6'h23;
  localparam logic [5:0] FUNC_JR   = 6'h08;

  // Instruction field bit positions
  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int FUNC_HI  = 5;
  localparam int FUNC_LO  = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int INDEX_HI = 25;
  localparam int INDEX_LO = 0;

  // Source of the next PC, in decreasing priority order
  typedef enum logic [1:0] {
    NPC_JR     = 2'd0,
    NPC_JAL    = 2'd1,
    NPC_BRANCH = 2'd2,
    NPC_SEQ    = 2'd3
  } npc_src_e;

  // Sign-extended, word-scaled beq offset
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_npc_sel.sv
// npc_sel: combinational next-PC selection for the fetch stage.
// Priority is jr, then jal, then taken beq, then sequential PC+4.
module npc_sel
  import mips_defs_pkg::*;
(
  input  logic [3:0]  pc_hi,
  input  logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        zero,
  input  logic        jal_flag,
  input  logic        jr_flag,
  input  logic [31:0] jr_target,
  input  logic [25:0] index26,
  input  logic [15:0] imm16,
  output logic [31:0] npc
);

  npc_src_e npc_src;

  // Pick the source with fixed priority so overlapping flags stay deterministic
  always_comb begin
    npc_src = NPC_SEQ;
    if (jr_flag) begin
      npc_src = NPC_JR;
    end else if (jal_flag) begin
      npc_src = NPC_JAL;
    end else if (branch && zero) begin
      npc_src = NPC_BRANCH;
    end
  end

  // Build the selected target; all adds wrap modulo 2^32
  always_comb begin
    npc = pc_plus4;
    case (npc_src)
      NPC_JR:     npc = jr_target;
      NPC_JAL:    npc = {pc_hi, index26, 2'b00};
      NPC_BRANCH: npc = pc_plus4 + branch_offset(imm16);
      default:    npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage of the single-cycle MIPS core. Holds the PC,
// reads the instruction ROM asynchronously and slices out the decode fields.
// Optional feature macro: PC_RANGE_CHECK_EN adds a sticky fault that stops
// fetch when the next PC is misaligned or outside the ROM window.
// The ROM array "im" carries no reset or write port; its image (IM_INIT_FILE)
// is placed by the memory-initialisation step of the implementation flow.
module instr_fetch_unit
  import mips_defs_pkg::*;
#(
  parameter logic [31:0] PC_RESET     = PC_RESET_DEFAULT,
  parameter int          IM_ADDR_W    = 12,
  parameter              IM_INIT_FILE = "code.txt"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_en,
  input  logic        branch,
  input  logic        zero,
  input  logic        jal_flag,
  input  logic        jr_flag,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [25:0] index26,
  output logic [31:0] retired,
  output logic        fault
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] npc;
  logic [31:0] rom_word;
  logic [IM_ADDR_W-1:0] rom_idx;

  logic [31:0] im [0:2**IM_ADDR_W-1];

  // Word index relative to the ROM base, wrapping modulo the ROM depth
  always_comb begin
    rom_idx = IM_ADDR_W'((pc_q - PC_RESET) >> 2);
  end

  assign rom_word = im[rom_idx];
  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign retired  = retired_q;

  npc_sel u_npc_sel (
    .pc_hi     (pc_q[31:28]),
    .pc_plus4  (pc_plus4),
    .branch    (branch),
    .zero      (zero),
    .jal_flag  (jal_flag),
    .jr_flag   (jr_flag),
    .jr_target (jr_target),
    .index26   (instr[INDEX_HI:INDEX_LO]),
    .imm16     (instr[IMM_HI:IMM_LO]),
    .npc       (npc)
  );

`ifdef PC_RANGE_CHECK_EN
  logic fault_q, fault_d;
  logic npc_bad;

  // Flag a next PC that is misaligned or beyond the last ROM word
  always_comb begin
    npc_bad = (npc[1:0] != 2'b00) ||
              (((npc - PC_RESET) >> (IM_ADDR_W + 2)) != 32'd0);
  end

  // Advance PC and count, or latch a fault instead of taking a bad target
  always_comb begin
    pc_d      = pc_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    if (pc_en && !fault_q) begin
      if (npc_bad) begin
        fault_d = 1'b1;
      end else begin
        pc_d      = npc;
        retired_d = retired_q + 32'd1;
      end
    end
  end

  // State registers; reset has priority over every update
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= PC_RESET;
      retired_q <= 32'd0;
      fault_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
    end
  end

  assign fault = fault_q;
  assign instr = fault_q ? 32'h0000_0000 : rom_word;
`else
  // Advance PC and count whenever enabled
  always_comb begin
    pc_d      = pc_q;
    retired_d = retired_q;
    if (pc_en) begin
      pc_d      = npc;
      retired_d = retired_q + 32'd1;
    end
  end

  // State registers; reset has priority over every update
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= PC_RESET;
      retired_q <= 32'd0;
    end else begin
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  assign fault = 1'b0;
  assign instr = rom_word;
`endif

  assign op      = instr[OP_HI:OP_LO];
  assign rs      = instr[RS_HI:RS_LO];
  assign rt      = instr[RT_HI:RT_LO];
  assign rd      = instr[RD_HI:RD_LO];
  assign func    = instr[FUNC_HI:FUNC_LO];
  assign imm16   = instr[IMM_HI:IMM_LO];
  assign index26 = instr[INDEX_HI:INDEX_LO];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: table-driven next-PC vectors plus
// hand-written reset, misalignment, range and wrap sequences.
module tb_instr_fetch_unit;
  import mips_defs_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pc_en = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        jal_flag = 1'b0;
  logic        jr_flag = 1'b0;
  logic [31:0] jr_target = 32'h0;
  logic [31:0] pc, pc_plus4, instr, retired;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [25:0] index26;
  logic        fault;

  int checks = 0;
  int failures = 0;

  logic [31:0] rom_model [0:4095];

  typedef struct {
    string       name;
    logic        pc_en;
    logic        branch;
    logic        zero;
    logic        jal;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] exp_pc;
    logic [31:0] exp_retired;
  } vec_t;

  vec_t vq[$];

  instr_fetch_unit #(
    .PC_RESET  (32'h0000_3000),
    .IM_ADDR_W (12)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_en     (pc_en),
    .branch    (branch),
    .zero      (zero),
    .jal_flag  (jal_flag),
    .jr_flag   (jr_flag),
    .jr_target (jr_target),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .instr     (instr),
    .op        (op),
    .func      (func),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .imm16     (imm16),
    .index26   (index26),
    .retired   (retired),
    .fault     (fault)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Expected instruction: ROM word at the wrapped word index, or zero on fault
  function automatic logic [31:0] modelInstr(input logic [31:0] p, input logic f);
    logic [31:0] off;
    off = (p - 32'h0000_3000) >> 2;
    if (f) return 32'h0;
    return rom_model[off[11:0]];
  endfunction

  task automatic addVec(input string n, input logic en, input logic br, input logic z,
                        input logic jl, input logic jrf, input logic [31:0] tgt,
                        input logic [31:0] epc, input logic [31:0] eret);
    vec_t v;
    v.name = n; v.pc_en = en; v.branch = br; v.zero = z; v.jal = jl; v.jr = jrf;
    v.jr_target = tgt; v.exp_pc = epc; v.exp_retired = eret;
    vq.push_back(v);
  endtask

  task automatic checkValue(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h", n, act, exp);
    end
  endtask

  // Compare every output against the bench model for the given state
  task automatic checkOutput(input string n, input logic [31:0] exp_pc,
                             input logic [31:0] exp_ret, input logic exp_fault);
    logic [31:0] ei;
    ei = modelInstr(exp_pc, exp_fault);
    checkValue({n, ".pc"}, pc, exp_pc);
    checkValue({n, ".pc_plus4"}, pc_plus4, exp_pc + 32'd4);
    checkValue({n, ".retired"}, retired, exp_ret);
    checkValue({n, ".fault"}, {31'd0, fault}, {31'd0, exp_fault});
    checkValue({n, ".instr"}, instr, ei);
    checkValue({n, ".op"}, {26'd0, op}, {26'd0, ei[31:26]});
    checkValue({n, ".rs"}, {27'd0, rs}, {27'd0, ei[25:21]});
    checkValue({n, ".rt"}, {27'd0, rt}, {27'd0, ei[20:16]});
    checkValue({n, ".rd"}, {27'd0, rd}, {27'd0, ei[15:11]});
    checkValue({n, ".func"}, {26'd0, func}, {26'd0, ei[5:0]});
    checkValue({n, ".imm16"}, {16'd0, imm16}, {16'd0, ei[15:0]});
    checkValue({n, ".index26"}, {6'd0, index26}, {6'd0, ei[25:0]});
  endtask

  task automatic stepCycle(input logic en, input logic br, input logic z,
                           input logic jl, input logic jrf, input logic [31:0] tgt);
    pc_en = en; branch = br; zero = z; jal_flag = jl; jr_flag = jrf; jr_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    stepCycle(v.pc_en, v.branch, v.zero, v.jal, v.jr, v.jr_target);
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    stepCycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_3100);
    reset = 1'b1;
  endtask

  initial begin
    // ROM image: generic words, with hand-placed ori, beq and jal
    for (int i = 0; i < 4096; i++) rom_model[i] = {16'hA5A5, 16'(i)};
    rom_model[0] = 32'h3408_0005;
    rom_model[4] = 32'h1000_FFFC;
    rom_model[8] = 32'h0C00_0C10;
    for (int i = 0; i < 4096; i++) dut.im[i] = rom_model[i];

    // Reset state and first fetched instruction
    reset = 1'b0;
    stepCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("reset", 32'h0000_3000, 32'd0, 1'b0);
    checkValue("reset.op_is_ori", {26'd0, op}, {26'd0, OP_ORI});
    checkValue("reset.rt_is_8", {27'd0, rt}, 32'd8);
    checkValue("reset.imm_is_5", {16'd0, imm16}, 32'd5);
    reset = 1'b1;

    // Table of single-cycle next-PC vectors
    addVec("seq1",        1, 0, 0, 0, 0, 32'h0,         32'h0000_3004, 32'd1);
    addVec("seq2",        1, 0, 0, 0, 0, 32'h0,         32'h0000_3008, 32'd2);
    addVec("seq3",        1, 0, 0, 0, 0, 32'h0,         32'h0000_300C, 32'd3);
    addVec("seq4",        1, 0, 0, 0, 0, 32'h0,         32'h0000_3010, 32'd4);
    addVec("beq_back",    1, 1, 1, 0, 0, 32'h0,         32'h0000_3004, 32'd5);
    addVec("seq5",        1, 0, 0, 0, 0, 32'h0,         32'h0000_3008, 32'd6);
    addVec("seq6",        1, 0, 0, 0, 0, 32'h0,         32'h0000_300C, 32'd7);
    addVec("seq7",        1, 0, 0, 0, 0, 32'h0,         32'h0000_3010, 32'd8);
    addVec("beq_nottkn",  1, 1, 0, 0, 0, 32'h0,         32'h0000_3014, 32'd9);
    addVec("jr_3020",     1, 0, 0, 0, 1, 32'h0000_3020, 32'h0000_3020, 32'd10);
    addVec("jal",         1, 0, 0, 1, 0, 32'h0,         32'h0000_3040, 32'd11);
    addVec("jr_over_jal", 1, 0, 0, 1, 1, 32'h0000_3024, 32'h0000_3024, 32'd12);
    addVec("hold1",       0, 1, 1, 1, 1, 32'h0000_3100, 32'h0000_3024, 32'd12);
    addVec("hold2",       0, 0, 0, 0, 1, 32'h0000_3100, 32'h0000_3024, 32'd12);
    addVec("hold3",       0, 1, 1, 0, 0, 32'h0000_3100, 32'h0000_3024, 32'd12);
    addVec("hold4",       0, 0, 0, 0, 0, 32'h0000_3100, 32'h0000_3024, 32'd12);
    addVec("beq_fwd",     1, 1, 1, 0, 0, 32'h0,         32'h0000_304C, 32'd13);
    addVec("jr_base",     1, 0, 0, 0, 1, 32'h0000_3000, 32'h0000_3000, 32'd14);
    addVec("seq8",        1, 0, 0, 0, 0, 32'h0,         32'h0000_3004, 32'd15);

    foreach (vq[k]) begin
      applyStimulus(vq[k]);
      checkOutput(vq[k].name, vq[k].exp_pc, vq[k].exp_retired, 1'b0);
    end

    // Reset mid-run overrides pc_en and all flags
    pulseReset();
    checkOutput("midrun_reset", 32'h0000_3000, 32'd0, 1'b0);

`ifdef PC_RANGE_CHECK_EN
    // Misaligned jr target faults, freezes, and only reset clears it
    stepCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3002);
    checkOutput("misalign_fault", 32'h0000_3000, 32'd0, 1'b1);
    stepCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("fault_frozen", 32'h0000_3000, 32'd0, 1'b1);
    pulseReset();
    checkOutput("fault_cleared", 32'h0000_3000, 32'd0, 1'b0);

    // Last ROM word is legal; the word after it faults
    stepCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_6FFC);
    checkOutput("last_word", 32'h0000_6FFC, 32'd1, 1'b0);
    stepCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("past_end_fault", 32'h0000_6FFC, 32'd1, 1'b1);
    pulseReset();

    // Below the base faults too
    stepCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2FFC);
    checkOutput("below_base_fault", 32'h0000_3000, 32'd0, 1'b1);
    pulseReset();
    checkOutput("fault_cleared2", 32'h0000_3000, 32'd0, 1'b0);
`else
    // Misaligned target is taken; ROM index truncates the low bits
    stepCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3002);
    checkOutput("misalign_taken", 32'h0000_3002, 32'd1, 1'b0);
    pulseReset();

    // Past the end of ROM wraps to word 0
    stepCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_7000);
    checkOutput("rom_wrap", 32'h0000_7000, 32'd1, 1'b0);
    stepCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rom_wrap_seq", 32'h0000_7004, 32'd2, 1'b0);
    pulseReset();

    // PC wraps from the top of the address space to zero
    stepCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    checkOutput("pc_top", 32'hFFFF_FFFC, 32'd1, 1'b0);
    stepCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("pc_wrap_zero", 32'h0000_0000, 32'd2, 1'b0);
    pulseReset();
    checkOutput("final_reset", 32'h0000_3000, 32'd0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
